// File: rtl/reset_seq_pkg.sv
// ============================================================================
//  Module   : reset_seq_pkg
//  Brief    : State encoding and default timing for the reset sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package reset_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] PLL_RST   = 3'd0;
  localparam logic [STATE_W-1:0] WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] REL_SDRAM = 3'd3;
  localparam logic [STATE_W-1:0] RUN       = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = PLL_RST,
    ST_WAIT_LOCK = WAIT_LOCK,
    ST_STABLE    = STABLE,
    ST_REL_SDRAM = REL_SDRAM,
    ST_RUN       = RUN
  } state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 65536;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_SDRAM_DELAY    = 256;
  localparam int DEF_CNT_W          = 17;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module   : sync_2ff
//  Brief    : Generic two-flop synchroniser with asynchronous active-low reset.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/reset_seq.sv
// ============================================================================
//  Module   : reset_seq
//  Brief    : PLL reset / lock-qualification sequencer releasing SDRAM then
//             Wishbone reset requests. Optional status via RESET_SEQ_STATUS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int SDRAM_DELAY    = DEF_SDRAM_DELAY,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       sys_clk_pad_i,
  input  logic       rst_n_pad_i,
  input  logic       pll_lock_i,
  output logic       pll_areset_o,
  output logic       sdram_rst_req_o,
  output logic       wb_rst_req_o,
  output logic       ready_o
`ifdef RESET_SEQ_STATUS_EN
  ,
  output logic [7:0] retry_cnt_o,
  output logic       lock_lost_o
`endif
);

  localparam logic [CNT_W-1:0] c_pll_term    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_lock_term   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_stable_term = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_sdram_term  = CNT_W'(SDRAM_DELAY - 1);

  state_e           r_state;
  state_e           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_term;
  logic             w_lock_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (sys_clk_pad_i),
    .rst_n (rst_n_pad_i),
    .i_d   (pll_lock_i),
    .o_q   (w_lock_s)
  );

  // Lock loss is checked before any terminal count so it always wins.
  always_comb begin
    w_nxt      = r_state;
    w_cnt_term = '0;
    case (r_state)
      ST_PLL_RST: begin
        w_cnt_term = c_pll_term;
        if (r_cnt == c_pll_term) w_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        w_cnt_term = c_lock_term;
        if (w_lock_s)                 w_nxt = ST_STABLE;
        else if (r_cnt == c_lock_term) w_nxt = ST_PLL_RST;
      end
      ST_STABLE: begin
        w_cnt_term = c_stable_term;
        if (!w_lock_s)                   w_nxt = ST_WAIT_LOCK;
        else if (r_cnt == c_stable_term) w_nxt = ST_REL_SDRAM;
      end
      ST_REL_SDRAM: begin
        w_cnt_term = c_sdram_term;
        if (!w_lock_s)                  w_nxt = ST_PLL_RST;
        else if (r_cnt == c_sdram_term) w_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_cnt_term = '0;
        if (!w_lock_s) w_nxt = ST_PLL_RST;
      end
      default: begin
        w_cnt_term = '0;
        w_nxt      = ST_PLL_RST;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      r_state         <= ST_PLL_RST;
      r_cnt           <= '0;
      pll_areset_o    <= 1'b1;
      sdram_rst_req_o <= 1'b1;
      wb_rst_req_o    <= 1'b1;
      ready_o         <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != w_cnt_term) begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (w_nxt)
        ST_WAIT_LOCK, ST_STABLE: begin
          pll_areset_o    <= 1'b0;
          sdram_rst_req_o <= 1'b1;
          wb_rst_req_o    <= 1'b1;
          ready_o         <= 1'b0;
        end
        ST_REL_SDRAM: begin
          pll_areset_o    <= 1'b0;
          sdram_rst_req_o <= 1'b0;
          wb_rst_req_o    <= 1'b1;
          ready_o         <= 1'b0;
        end
        ST_RUN: begin
          pll_areset_o    <= 1'b0;
          sdram_rst_req_o <= 1'b0;
          wb_rst_req_o    <= 1'b0;
          ready_o         <= 1'b1;
        end
        default: begin
          pll_areset_o    <= 1'b1;
          sdram_rst_req_o <= 1'b1;
          wb_rst_req_o    <= 1'b1;
          ready_o         <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESET_SEQ_STATUS_EN
  logic w_timeout;
  logic w_lost;

  assign w_timeout = (r_state == ST_WAIT_LOCK) && !w_lock_s && (r_cnt == c_lock_term);
  assign w_lost    = ((r_state == ST_REL_SDRAM) || (r_state == ST_RUN)) && !w_lock_s;

  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      retry_cnt_o <= 8'd0;
      lock_lost_o <= 1'b0;
    end else begin
      if (w_timeout && (retry_cnt_o != 8'hFF)) retry_cnt_o <= retry_cnt_o + 8'd1;
      if (w_lost)                              lock_lost_o <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
